// File: rtl/chunk_serial_adder_if.sv
// Operand/result handshake bundle for chunk_serial_adder.
// The master drives operands and out_ready; the slave (the adder) drives results and in_ready.
interface chunk_serial_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );
endinterface

// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder/subtractor: sums CHUNK bits per clock, LSB chunk first, with a registered
// carry between chunks. Reports carry-out (no-borrow for subtraction) and signed overflow.
module chunk_serial_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic                clk,
  input logic                rst,
  chunk_serial_adder_if.slave bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] chunk_mask;
  logic [WIDTH-1:0] r_ins;
  logic             last;

  // Chunk extraction/insertion by shifting, so CHUNK==WIDTH needs no special case.
  always_comb begin
    base       = 32'(k_q) * CHUNK;
    a_chunk    = CHUNK'(a_q >> base);
    b_chunk    = CHUNK'(b_q >> base);
    chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    chunk_mask = WIDTH'({CHUNK{1'b1}}) << base;
    r_ins      = (r_q & ~chunk_mask) | (WIDTH'(chunk_sum[CHUNK-1:0]) << base);
    last       = (k_q == KW'(NCHUNK - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    k_d     = k_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          // Subtraction as a + ~b + ~ci == a - b - ci.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? ~bus.ci : bus.ci;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        r_d     = r_ins;
        carry_d = chunk_sum[CHUNK];
        k_d     = k_q + 1'b1;
        if (last) begin
          sum_d   = r_ins;
          co_d    = chunk_sum[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (r_ins[WIDTH-1] != a_q[WIDTH-1]);
          k_d     = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs come straight from the state register: no input-to-output paths.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed and randomised checks of chunk_serial_adder at CHUNK = 8, plus 1, 4 and 32 instances.
module tb_chunk_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  chunk_serial_adder_if #(.WIDTH(32)) if8  ();
  chunk_serial_adder_if #(.WIDTH(32)) if1  ();
  chunk_serial_adder_if #(.WIDTH(32)) if4  ();
  chunk_serial_adder_if #(.WIDTH(32)) if32 ();

  chunk_serial_adder #(.WIDTH(32), .CHUNK(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  chunk_serial_adder #(.WIDTH(32), .CHUNK(1))  dut1  (.clk(clk), .rst(rst), .bus(if1.slave));
  chunk_serial_adder #(.WIDTH(32), .CHUNK(4))  dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
  chunk_serial_adder #(.WIDTH(32), .CHUNK(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

  // Issue one operation on the CHUNK=8 instance and complete its output handshake.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic sub, output logic [31:0] s, output logic c,
                        output logic o, output int lat);
    if8.a = a; if8.b = b; if8.ci = ci; if8.sub = sub; if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!if8.out_valid) lat = -1;
    s = if8.sum; c = if8.co; o = if8.ovf;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if8.out_valid !== 1'b0 || if8.sum !== 32'h0 || if8.co !== 1'b0 || if8.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ov=%b sum=%h co=%b ovf=%b, want 0/0/0/0",
               if8.out_valid, if8.sum, if8.co, if8.ovf);
    end
    n_checks++;
    if (if8.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", if8.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] s; logic c, o; int lat;
    run_op(32'h0000_00FF, 32'h1, 1'b0, 1'b0, s, c, o, lat);
    n_checks++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL latency: got %0d want 4", lat);
    end
    n_checks++;
    if ({s, c, o} !== {32'h0000_0100, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL add_ff_1: got %h co=%b ovf=%b want 00000100 0 0", s, c, o);
    end
    n_checks++;
    if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_idle: got ov=%b ir=%b want 0 1", if8.out_valid, if8.in_ready);
    end
    run_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, s, c, o, lat);
    n_checks++;
    if ({s, c, o} !== {32'h0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL full_ripple: got %h co=%b ovf=%b want 00000000 1 0", s, c, o);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] s; logic c, o; int lat;
    run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, s, c, o, lat);
    n_checks++;
    if ({s, c, o} !== {32'h8000_0000, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL ovf_add: got %h co=%b ovf=%b want 80000000 0 1", s, c, o);
    end
    run_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, s, c, o, lat);
    n_checks++;
    if ({s, c, o} !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL ovf_sub: got %h co=%b ovf=%b want 7fffffff 1 1", s, c, o);
    end
  endtask

  task automatic test_borrow();
    logic [31:0] s; logic c, o; int lat;
    run_op(32'd5, 32'd7, 1'b0, 1'b1, s, c, o, lat);
    n_checks++;
    if ({s, c, o} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL borrow: got %h co=%b ovf=%b want fffffffe 0 0", s, c, o);
    end
    run_op(32'd5, 32'd7, 1'b1, 1'b1, s, c, o, lat);
    n_checks++;
    if ({s, c, o} !== {32'hFFFF_FFFD, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL borrow_ci: got %h co=%b ovf=%b want fffffffd 0 0", s, c, o);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    if8.out_ready = 1'b0;
    if8.a = 32'd10; if8.b = 32'd20; if8.ci = 1'b0; if8.sub = 1'b0; if8.in_valid = 1'b1;
    @(negedge clk);
    // New operands held valid throughout RUN and DONE must not be taken.
    if8.a = 32'd100; if8.b = 32'd23;
    lat = 0;
    while (!if8.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (!if8.out_valid) begin
      n_fail++; $display("FAIL bp_done_timeout: got out_valid=0 want 1");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (if8.out_valid !== 1'b1 || if8.in_ready !== 1'b0 || if8.sum !== 32'd30) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b sum=%h want 1 0 0000001e",
                 i, if8.out_valid, if8.in_ready, if8.sum);
      end
    end
    if8.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got ov=%b ir=%b want 0 1", if8.out_valid, if8.in_ready);
    end
    @(negedge clk);
    if8.in_valid = 1'b0;
    n_checks++;
    if (if8.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_accept_next: got in_ready=%b want 0", if8.in_ready);
    end
    lat = 0;
    while (!if8.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (if8.out_valid !== 1'b1 || if8.sum !== 32'd123) begin
      n_fail++;
      $display("FAIL bp_held_op: got ov=%b sum=%h want 1 0000007b", if8.out_valid, if8.sum);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] s; logic c, o; int lat;
    if8.a = 32'd1; if8.b = 32'd1; if8.ci = 1'b0; if8.sub = 1'b0; if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1 || if8.sum !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got ov=%b ir=%b sum=%h want 0 1 00000000",
               if8.out_valid, if8.in_ready, if8.sum);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (if8.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_no_pulse: got out_valid=%b want 0", if8.out_valid);
    end
    run_op(32'd3, 32'd4, 1'b0, 1'b0, s, c, o, lat);
    n_checks++;
    if ({s, c, o} !== {32'd7, 1'b0, 1'b0} || lat !== 4) begin
      n_fail++;
      $display("FAIL after_reset: got %h co=%b ovf=%b lat=%0d want 00000007 0 0 4", s, c, o, lat);
    end
  endtask

  // Same random operands on all four chunk widths, compared against an integer model.
  task automatic test_random();
    logic [31:0] ra, rb; logic rci, rsub;
    logic [32:0] full;
    longint      sr;
    logic [31:0] es; logic ec, eo;
    logic        got [4];
    logic [31:0] gs  [4];
    logic        gc  [4];
    logic        go  [4];
    for (int it = 0; it < 24; it++) begin
      ra = $urandom; rb = $urandom; rci = 1'($urandom); rsub = 1'(it % 2);
      if (it == 0) begin ra = 32'h7FFF_FFFF; rb = 32'h8000_0000; rsub = 1'b1; end
      if (rsub) begin
        full = {1'b0, ra} + {1'b0, ~rb} + {32'h0, ~rci};
        sr   = longint'($signed(ra)) - longint'($signed(rb)) - longint'(rci);
      end else begin
        full = {1'b0, ra} + {1'b0, rb} + {32'h0, rci};
        sr   = longint'($signed(ra)) + longint'($signed(rb)) + longint'(rci);
      end
      es = full[31:0]; ec = full[32];
      eo = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      if8.a = ra;  if8.b = rb;  if8.ci = rci;  if8.sub = rsub;  if8.in_valid = 1'b1;
      if1.a = ra;  if1.b = rb;  if1.ci = rci;  if1.sub = rsub;  if1.in_valid = 1'b1;
      if4.a = ra;  if4.b = rb;  if4.ci = rci;  if4.sub = rsub;  if4.in_valid = 1'b1;
      if32.a = ra; if32.b = rb; if32.ci = rci; if32.sub = rsub; if32.in_valid = 1'b1;
      for (int j = 0; j < 4; j++) got[j] = 1'b0;
      @(negedge clk);
      if8.in_valid = 1'b0; if1.in_valid = 1'b0; if4.in_valid = 1'b0; if32.in_valid = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        if (if8.out_valid && !got[0]) begin
          got[0] = 1'b1; gs[0] = if8.sum; gc[0] = if8.co; go[0] = if8.ovf;
        end
        if (if1.out_valid && !got[1]) begin
          got[1] = 1'b1; gs[1] = if1.sum; gc[1] = if1.co; go[1] = if1.ovf;
        end
        if (if4.out_valid && !got[2]) begin
          got[2] = 1'b1; gs[2] = if4.sum; gc[2] = if4.co; go[2] = if4.ovf;
        end
        if (if32.out_valid && !got[3]) begin
          got[3] = 1'b1; gs[3] = if32.sum; gc[3] = if32.co; go[3] = if32.ovf;
        end
        @(negedge clk);
      end
      for (int j = 0; j < 4; j++) begin
        n_checks++;
        if (!got[j]) begin
          n_fail++; $display("FAIL rand[%0d] dut%0d: no out_valid within 40 cycles", it, j);
        end else if ({gs[j], gc[j], go[j]} !== {es, ec, eo}) begin
          n_fail++;
          $display("FAIL rand[%0d] dut%0d: a=%h b=%h ci=%b sub=%b got %h/%b/%b want %h/%b/%b",
                   it, j, ra, rb, rci, rsub, gs[j], gc[j], go[j], es, ec, eo);
        end
      end
    end
  endtask

  initial begin
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.ci = 1'b0; if8.sub = 1'b0;
    if8.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.ci = 1'b0; if1.sub = 1'b0;
    if1.out_ready = 1'b1;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.ci = 1'b0; if4.sub = 1'b0;
    if4.out_ready = 1'b1;
    if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.ci = 1'b0; if32.sub = 1'b0;
    if32.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_overflow();
    test_borrow();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
